level_ctrl: RTL and testbench

Game-progression controller for Moon Landers: the producer of the 3-bit `level` code that the HEX level display consumes. It sequences idle → stage 1 → 2 → 3 → end, inserts a fixed pause before each round, tracks remaining lives, and reports win/loss. Its outputs drive the level display, the lander physics block (`round_go`, `playing`) and the result indicators.

---
 rtl/level_ctrl_if.sv | 20 ++
 rtl/level_ctrl.sv | 109 ++++++++++
 tb/tb_level_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/level_ctrl_if.sv
// level_ctrl_if: game-progression signal bundle between the level controller and its consumers.
//   start/landed/crashed : game events into the controller
//   level/lives          : display codes out of the controller
//   playing/round_go     : physics enables out of the controller
//   won/lost             : result flags out of the controller
interface level_ctrl_if;
  logic       start;
  logic       landed;
  logic       crashed;
  logic [2:0] level;
  logic [1:0] lives;
  logic       playing;
  logic       round_go;
  logic       won;
  logic       lost;
  modport master (output start, landed, crashed,
                  input  level, lives, playing, round_go, won, lost);
  modport slave  (input  start, landed, crashed,
                  output level, lives, playing, round_go, won, lost);
endinterface

// File: rtl/level_ctrl.sv
// level_ctrl: Moon Landers game sequencer (idle -> stages 1..3 -> done) with a pre-round pause and lives.
//   clock : system clock, rising edge
//   Reset : synchronous, active-low
//   bus   : level_ctrl_if.slave carrying the start/landed/crashed inputs and the
//           level/lives/playing/round_go/won/lost outputs
module level_ctrl #(
  parameter int PAUSE_CYCLES = 50_000_000,
  parameter int LIVES        = 3,
  parameter int CNT_W        = 26
) (
  input logic          clock,
  input logic          Reset,
  level_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, PAUSE, PLAY, DONE} state_t;
  localparam logic [CNT_W-1:0] RELOAD     = CNT_W'(PAUSE_CYCLES - 1);
  localparam logic [1:0]       LIVES_INIT = 2'(LIVES);
  state_t           state_q, state_d;
  logic [1:0]       stage_q, stage_d, lives_q, lives_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             won_q, won_d, lost_q, lost_d, go_q, go_d, start_q;
  logic             start_edge;
  // start_q resets high so a button held through reset does not start a game
  assign start_edge = bus.start & ~start_q;
  always_ff @(posedge clock) begin
    if (!Reset) begin
      state_q <= IDLE;
      stage_q <= 2'd1;
      lives_q <= LIVES_INIT;
      timer_q <= '0;
      won_q   <= 1'b0;
      lost_q  <= 1'b0;
      go_q    <= 1'b0;
      start_q <= 1'b1;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      lives_q <= lives_d;
      timer_q <= timer_d;
      won_q   <= won_d;
      lost_q  <= lost_d;
      go_q    <= go_d;
      start_q <= bus.start;
    end
  end
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    lives_d = lives_q;
    timer_d = timer_q;
    won_d   = won_q;
    lost_d  = lost_q;
    go_d    = 1'b0;
    case (state_q)
      IDLE:
        if (start_edge) begin
          state_d = PAUSE;
          stage_d = 2'd1;
          lives_d = LIVES_INIT;
          timer_d = RELOAD;
        end
      // timer is loaded with PAUSE_CYCLES-1 so the exit edge lands exactly PAUSE_CYCLES edges after entry
      PAUSE:
        if (timer_q == '0) begin
          state_d = PLAY;
          go_d    = 1'b1;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      // a crash outranks a landing reported in the same cycle
      PLAY:
        if (bus.crashed) begin
          if (lives_q == 2'd1) begin
            lives_d = 2'd0;
            state_d = DONE;
            lost_d  = 1'b1;
          end else begin
            lives_d = lives_q - 2'd1;
            state_d = PAUSE;
            timer_d = RELOAD;
          end
        end else if (bus.landed) begin
          if (stage_q == 2'd3) begin
            state_d = DONE;
            won_d   = 1'b1;
          end else begin
            stage_d = stage_q + 2'd1;
            state_d = PAUSE;
            timer_d = RELOAD;
          end
        end
      DONE:
        if (start_edge) begin
          state_d = IDLE;
          won_d   = 1'b0;
          lost_d  = 1'b0;
          lives_d = LIVES_INIT;
          stage_d = 2'd1;
        end
      default: state_d = IDLE;
    endcase
  end
  assign bus.level    = state_q == IDLE ? 3'd0 : state_q == DONE ? 3'd4 : {1'b0, stage_q};
  assign bus.lives    = lives_q;
  assign bus.playing  = state_q == PLAY;
  assign bus.round_go = go_q;
  assign bus.won      = won_q;
  assign bus.lost     = lost_q;
endmodule

// File: tb/tb_level_ctrl.sv
// tb_level_ctrl: scenario-driven scoreboard bench for level_ctrl with PAUSE_CYCLES=4, LIVES=3.
module tb_level_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int failures = 0;
  logic [8:0] exp_q[$];
  logic [8:0] got, exp;
  level_ctrl_if bus ();
  level_ctrl #(.PAUSE_CYCLES(4), .LIVES(3), .CNT_W(3)) dut (.clock(clk), .Reset(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // packed view: level, lives, playing, round_go, won, lost
  function automatic logic [8:0] snap();
    return {bus.level, bus.lives, bus.playing, bus.round_go, bus.won, bus.lost};
  endfunction
  function automatic logic [8:0] mk(logic [2:0] lv, logic [1:0] li, logic p, logic g, logic w, logic l);
    return {lv, li, p, g, w, l};
  endfunction
  task automatic wait_go(output int n);
    n = 0;
    while (bus.round_go !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL round_go_timeout waited=%0d cycles, required a round_go pulse", n);
    end
  endtask
  task automatic test_reset();
    rst_n = 1'b0; bus.start = 1'b1; bus.landed = 1'b0; bus.crashed = 1'b0;
    repeat (3) tick();
    exp_q.push_back(mk(3'd0, 2'd3, 0, 0, 0, 0));
    got = snap(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL reset got=%b exp=%b", got, exp); end
    rst_n = 1'b1;
    exp_q.push_back(mk(3'd0, 2'd3, 0, 0, 0, 0));
    repeat (4) tick();
    got = snap(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL held_start got=%b exp=%b", got, exp); end
    bus.start = 1'b0;
    exp_q.push_back(mk(3'd0, 2'd3, 0, 0, 0, 0));
    tick();
    got = snap(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL start_low_idle got=%b exp=%b", got, exp); end
  endtask
  task automatic test_full_win();
    int n;
    bus.start = 1'b1;
    exp_q.push_back(mk(3'd1, 2'd3, 0, 0, 0, 0));
    tick(); bus.start = 1'b0;
    got = snap(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL start_latency got=%b exp=%b", got, exp); end
    wait_go(n);
    checks++;
    if (n !== 4) begin failures++; $display("FAIL pause_len got=%0d exp=4", n); end
    exp_q.push_back(mk(3'd1, 2'd3, 1, 1, 0, 0));
    got = snap(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL round1_go got=%b exp=%b", got, exp); end
    bus.landed = 1'b1;
    exp_q.push_back(mk(3'd2, 2'd3, 0, 0, 0, 0));
    tick(); bus.landed = 1'b0;
    got = snap(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL land1 got=%b exp=%b", got, exp); end
    wait_go(n);
    bus.landed = 1'b1;
    exp_q.push_back(mk(3'd3, 2'd3, 0, 0, 0, 0));
    tick(); bus.landed = 1'b0;
    got = snap(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL land2 got=%b exp=%b", got, exp); end
    wait_go(n);
    bus.landed = 1'b1;
    exp_q.push_back(mk(3'd4, 2'd3, 0, 0, 1, 0));
    tick(); bus.landed = 1'b0;
    got = snap(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL win got=%b exp=%b", got, exp); end
    exp_q.push_back(mk(3'd4, 2'd3, 0, 0, 1, 0));
    repeat (3) tick();
    got = snap(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL done_hold got=%b exp=%b", got, exp); end
  endtask
  task automatic test_restart();
    bus.start = 1'b1;
    exp_q.push_back(mk(3'd0, 2'd3, 0, 0, 0, 0));
    tick(); bus.start = 1'b0;
    got = snap(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL restart_idle got=%b exp=%b", got, exp); end
    tick();
    bus.start = 1'b1;
    exp_q.push_back(mk(3'd1, 2'd3, 0, 0, 0, 0));
    tick(); bus.start = 1'b0;
    got = snap(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL restart_start got=%b exp=%b", got, exp); end
  endtask
  task automatic test_loss();
    int n;
    wait_go(n);
    bus.landed = 1'b1;
    exp_q.push_back(mk(3'd2, 2'd3, 0, 0, 0, 0));
    tick(); bus.landed = 1'b0;
    got = snap(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL loss_reach_stage2 got=%b exp=%b", got, exp); end
    for (int i = 0; i < 3; i++) begin
      wait_go(n);
      bus.crashed = 1'b1;
      exp_q.push_back(i == 2 ? mk(3'd4, 2'd0, 0, 0, 0, 1) : mk(3'd2, 2'(2 - i), 0, 0, 0, 0));
      tick(); bus.crashed = 1'b0;
      got = snap(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL crash%0d got=%b exp=%b", i + 1, got, exp); end
    end
  endtask
  task automatic test_ignored();
    bus.start = 1'b1;
    exp_q.push_back(mk(3'd0, 2'd3, 0, 0, 0, 0));
    tick(); bus.start = 1'b0;
    got = snap(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL lost_to_idle got=%b exp=%b", got, exp); end
    bus.landed = 1'b1; bus.crashed = 1'b1;
    exp_q.push_back(mk(3'd0, 2'd3, 0, 0, 0, 0));
    tick(); bus.landed = 1'b0; bus.crashed = 1'b0;
    got = snap(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL idle_events got=%b exp=%b", got, exp); end
    bus.start = 1'b1;
    tick(); bus.start = 1'b0;
    bus.landed = 1'b1;
    exp_q.push_back(mk(3'd1, 2'd3, 0, 0, 0, 0));
    tick(); bus.landed = 1'b0;
    got = snap(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL pause_landed got=%b exp=%b", got, exp); end
    bus.crashed = 1'b1;
    exp_q.push_back(mk(3'd1, 2'd3, 0, 0, 0, 0));
    tick(); bus.crashed = 1'b0;
    got = snap(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL pause_crashed got=%b exp=%b", got, exp); end
    tick();
    bus.landed = 1'b1;
    exp_q.push_back(mk(3'd1, 2'd3, 1, 1, 0, 0));
    tick(); bus.landed = 1'b0;
    got = snap(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL edge_event_ignored got=%b exp=%b", got, exp); end
    bus.landed = 1'b1; bus.crashed = 1'b1;
    exp_q.push_back(mk(3'd1, 2'd2, 0, 0, 0, 0));
    tick(); bus.landed = 1'b0; bus.crashed = 1'b0;
    got = snap(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL simultaneous got=%b exp=%b", got, exp); end
  endtask
  task automatic test_reset_mid_pause();
    int n;
    int gos;
    for (int i = 0; i < 2; i++) begin
      wait_go(n);
      bus.landed = 1'b1;
      exp_q.push_back(mk(3'(i + 2), 2'd2, 0, 0, 0, 0));
      tick(); bus.landed = 1'b0;
      got = snap(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL advance_stage%0d got=%b exp=%b", i + 2, got, exp); end
    end
    repeat (2) tick();
    rst_n = 1'b0;
    exp_q.push_back(mk(3'd0, 2'd3, 0, 0, 0, 0));
    tick(); rst_n = 1'b1;
    got = snap(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL mid_pause_reset got=%b exp=%b", got, exp); end
    gos = 0;
    repeat (10) begin
      tick();
      if (bus.round_go === 1'b1) gos++;
    end
    checks++;
    if (gos !== 0) begin failures++; $display("FAIL aborted_round_go got=%0d pulses exp=0", gos); end
    exp_q.push_back(mk(3'd0, 2'd3, 0, 0, 0, 0));
    got = snap(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL post_reset_idle got=%b exp=%b", got, exp); end
  endtask
  initial begin
    test_reset();
    test_full_win();
    test_restart();
    test_loss();
    test_ignored();
    test_reset_mid_pause();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
